// File: rtl/cardinal_pkg.sv
// cardinal_pkg: PPP encodings, PPP byte-mask helper and opcode constants for the Cardinal pipeline
package cardinal_pkg;
  localparam logic [2:0] PPP_ALL    = 3'b000;
  localparam logic [2:0] PPP_FIRST  = 3'b001;
  localparam logic [2:0] PPP_SECOND = 3'b010;
  localparam logic [2:0] PPP_EVEN   = 3'b011;
  localparam logic [2:0] PPP_ODD    = 3'b100;
  localparam logic [6:0] OP_R_ALU  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  // byte_index 0 is the most significant byte; encodings 101-111 select all bytes like PPP_ALL
  function automatic logic ppp_byte_mask(input logic [2:0] ppp, input int byte_index, input int nbytes);
    return ppp == PPP_FIRST  ? byte_index < nbytes / 2 :
           ppp == PPP_SECOND ? byte_index >= nbytes / 2 :
           ppp == PPP_EVEN   ? ~byte_index[0] :
           ppp == PPP_ODD    ? byte_index[0] : 1'b1;
  endfunction
endpackage

// File: rtl/cardinal_hazard_unit_merge.sv
// cardinal_ppp_merge: substitutes PPP-selected writeback bytes into N operands whose source matches wb_rd_addr
// Ports: en (writeback live), wb_rd_addr/wb_ppp/wb_data (writeback), src/old (per-operand source and value), merged (result)
module cardinal_ppp_merge import cardinal_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int N      = 1
) (
  input  logic                          en,
  input  logic [REG_AW-1:0]             wb_rd_addr,
  input  logic [2:0]                    wb_ppp,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic [N-1:0][REG_AW-1:0]      src,
  input  logic [N-1:0][DATA_W-1:0]      old,
  output logic [N-1:0][DATA_W-1:0]      merged
);
  localparam int NB = DATA_W / 8;
  for (genvar k = 0; k < N; k++) begin : g_op
    logic hit;
    assign hit = en && src[k] != '0 && src[k] == wb_rd_addr;
    for (genvar j = 0; j < NB; j++) begin : g_byte
      localparam int LSB = DATA_W - 8 * (j + 1);
      assign merged[k][LSB+:8] = hit && ppp_byte_mask(wb_ppp, j, NB) ? wb_data[LSB+:8] : old[k][LSB+:8];
    end
  end
endmodule

// File: rtl/cardinal_hazard_unit.sv
// cardinal_hazard_unit: ID/EX hazard detection, latency scoreboard, WB-port conflict check and PPP operand forwarding
// Ports: Clock/Reset; id_* (ID instruction), rf_rs*_data (RF reads), wb_* (writeback),
//        stall/issue (ID control), id_br_data (bypassed branch operand), ex_valid/ex_op_a/ex_op_b (EX operands)
// Option: CARDINAL_EX_FWD_EN enables EX-stage forwarding and relaxes the operand-hazard threshold to rem >= 2
module cardinal_hazard_unit import cardinal_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int LD_LAT = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              id_valid,
  input  logic              id_kill,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_en,
  input  logic              id_rs2_en,
  input  logic              id_is_branch,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_rd_wr,
  input  logic              id_is_load,
  input  logic [2:0]        id_ppp,
  input  logic [DATA_W-1:0] rf_rs1_data,
  input  logic [DATA_W-1:0] rf_rs2_data,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [2:0]        wb_ppp,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              issue,
  output logic [DATA_W-1:0] id_br_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b
);
`ifdef CARDINAL_EX_FWD_EN
  localparam int   THR    = 2;
  localparam logic EX_FWD = 1'b1;
`else
  localparam int   THR    = 1;
  localparam logic EX_FWD = 1'b0;
`endif
  localparam int SW = $clog2(LD_LAT + 1);
  logic [LD_LAT:0]             sb_v;
  logic [LD_LAT:0][REG_AW-1:0] sb_rd;
  logic [SW-1:0]               wr_lat;
  logic                        op_haz, br_haz, wb_haz, wb_en, rs1_use, rs2_use, unused_ppp;
  logic [1:0][DATA_W-1:0]      id_m, ex_m;
  logic [DATA_W-1:0]           br_m, ex_a_q, ex_b_q;
  logic [REG_AW-1:0]           ex_rs1_q, ex_rs2_q;
  // the scoreboard treats every write as full-width, so the write's PPP plays no part in hazards
  assign unused_ppp = ^id_ppp;
  assign wb_en      = wb_valid && !Reset;
  assign wr_lat     = id_is_load ? SW'(LD_LAT) : SW'(1);
  assign rs1_use    = id_rs1_en && id_rs1_addr != '0;
  assign rs2_use    = id_rs2_en && id_rs2_addr != '0;
  always_comb begin
    op_haz = 1'b0;
    br_haz = 1'b0;
    wb_haz = 1'b0;
    for (int r = 0; r <= LD_LAT; r++) begin
      op_haz |= sb_v[r] && r >= THR && ((rs1_use && sb_rd[r] == id_rs1_addr) || (rs2_use && sb_rd[r] == id_rs2_addr));
      br_haz |= sb_v[r] && r >= 1 && id_is_branch && id_rs1_addr != '0 && sb_rd[r] == id_rs1_addr;
      // a write landing at rem L next cycle collides with whatever already sits at rem L+1 now
      wb_haz |= sb_v[r] && id_rd_wr && r == int'(wr_lat) + 1;
    end
  end
  assign stall = id_valid && !id_kill && (op_haz || br_haz || wb_haz);
  assign issue = id_valid && !id_kill && !stall;
  cardinal_ppp_merge #(.DATA_W(DATA_W), .REG_AW(REG_AW), .N(2)) u_id (
    .en(wb_en), .wb_rd_addr(wb_rd_addr), .wb_ppp(wb_ppp), .wb_data(wb_data),
    .src({id_rs2_addr, id_rs1_addr}), .old({rf_rs2_data, rf_rs1_data}), .merged(id_m)
  );
  cardinal_ppp_merge #(.DATA_W(DATA_W), .REG_AW(REG_AW), .N(2)) u_ex (
    .en(wb_en && ex_valid && EX_FWD), .wb_rd_addr(wb_rd_addr), .wb_ppp(wb_ppp), .wb_data(wb_data),
    .src({ex_rs2_q, ex_rs1_q}), .old({ex_b_q, ex_a_q}), .merged(ex_m)
  );
  cardinal_ppp_merge #(.DATA_W(DATA_W), .REG_AW(REG_AW), .N(1)) u_br (
    .en(wb_en), .wb_rd_addr(wb_rd_addr), .wb_ppp(wb_ppp), .wb_data(wb_data),
    .src(id_rs1_addr), .old(rf_rs1_data), .merged(br_m)
  );
  assign id_br_data = id_rs1_addr == '0 ? '0 : br_m;
  assign ex_op_a    = ex_m[0];
  assign ex_op_b    = ex_m[1];
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sb_v     <= '0;
      sb_rd    <= '0;
      ex_valid <= 1'b0;
      ex_a_q   <= '0;
      ex_b_q   <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
    end else begin
      sb_v     <= {1'b0, sb_v[LD_LAT:1]};
      sb_rd    <= {{REG_AW{1'b0}}, sb_rd[LD_LAT:1]};
      if (issue && id_rd_wr && id_rd_addr != '0) begin
        sb_v[wr_lat]  <= 1'b1;
        sb_rd[wr_lat] <= id_rd_addr;
      end
      ex_valid <= issue;
      if (issue) begin
        ex_a_q   <= rs1_use ? id_m[0] : '0;
        ex_b_q   <= rs2_use ? id_m[1] : '0;
        ex_rs1_q <= rs1_use ? id_rs1_addr : '0;
        ex_rs2_q <= rs2_use ? id_rs2_addr : '0;
      end
    end
  end
endmodule
